// File: rtl/spi_ctrl_pkg.sv
// Shared state encoding and default sizes for the SPI transaction sequencer.
package spi_ctrl_pkg;

    localparam int STATE_W       = 4;
    localparam int ADDR_BITS_DEF = 7;
    localparam int DATA_BITS_DEF = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 4'd0,
        GET    = 4'd1,
        GOT    = 4'd2,
        READ1  = 4'd3,
        READ2  = 4'd4,
        READ3  = 4'd5,
        WRITE  = 4'd6,
        WRITE2 = 4'd7,
        DONE   = 4'd8
    } state_t;

endpackage

// File: rtl/spi_bit_counter.sv
// Strobe counter with synchronous clear; hit flags the strobe that reaches term.
module spi_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             hit
);

    logic [CNT_W-1:0] count;

    // hit is combinational so the FSM leaves its state on the terminal strobe itself
    assign hit = en && ((count + CNT_W'(1)) == term);

    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (en)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/spi_txn_ctrl.sv
// SPI slave transaction sequencer: orders address latch, shift load, memory write, MISO drive.
// Optional SPI_TXN_CNT_EN adds txn_count / abort_flag status outputs.
module spi_txn_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cs,
    input  logic               sclk_pos,
    input  logic               sclk_neg,
    input  logic               rw_bit,
    output logic               ad_we,
    output logic               sr_we,
    output logic               dm_we,
    output logic               miso_buff,
    output logic               busy,
`ifdef SPI_TXN_CNT_EN
    output logic [7:0]         txn_count,
    output logic               abort_flag,
`endif
    output logic [STATE_W-1:0] state_o
);

    localparam int CNT_W = $clog2(ADDR_BITS + DATA_BITS + 1);
    localparam logic [CNT_W-1:0] ADDR_TERM = CNT_W'(ADDR_BITS + 1);
    localparam logic [CNT_W-1:0] DATA_TERM = CNT_W'(DATA_BITS);

    state_t           state, nxt;
    logic             cnt_en, cnt_hit, cnt_clr;
    logic [CNT_W-1:0] cnt_term;

    always_comb begin
        cnt_en   = 1'b0;
        cnt_term = DATA_TERM;
        // Each counting state listens to exactly one strobe; the other is ignored.
        case (state)
            GET:     begin cnt_en = sclk_pos; cnt_term = ADDR_TERM; end
            WRITE:   cnt_en = sclk_pos;
            READ3:   cnt_en = sclk_neg;
            default: cnt_en = 1'b0;
        endcase
        if (cs)
            cnt_en = 1'b0;
    end

    always_comb begin
        nxt = state;
        if (cs) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:    nxt = GET;
                GET:     if (cnt_hit) nxt = GOT;
                GOT:     nxt = rw_bit ? READ1 : WRITE;
                READ1:   nxt = READ2;
                READ2:   nxt = READ3;
                READ3:   if (cnt_hit) nxt = DONE;
                WRITE:   if (cnt_hit) nxt = WRITE2;
                WRITE2:  nxt = DONE;
                DONE:    nxt = DONE;
                default: nxt = IDLE;
            endcase
        end
    end

    assign cnt_clr = reset || (nxt != state);

    spi_bit_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .term (cnt_term),
        .hit  (cnt_hit)
    );

    // Enables are registered from the next state so each equals a decode of the held state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ad_we     <= 1'b0;
            sr_we     <= 1'b0;
            dm_we     <= 1'b0;
            miso_buff <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt;
            ad_we     <= (nxt == GOT);
            sr_we     <= (nxt == READ2);
            dm_we     <= (nxt == WRITE2);
            miso_buff <= (nxt == READ3);
            busy      <= (nxt != IDLE);
        end
    end

    assign state_o = state;

`ifdef SPI_TXN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            txn_count  <= 8'd0;
            abort_flag <= 1'b0;
        end else begin
            if (nxt == DONE && state != DONE)
                txn_count <= txn_count + 8'd1;
            if (cs && state != IDLE && state != DONE)
                abort_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Self-checking bench: directed read/write/abort/reset scenarios plus random traffic vs a phase model.
module tb_spi_txn_ctrl;

    logic       clk = 1'b0;
    logic       reset, cs, sclk_pos, sclk_neg, rw_bit;
    logic       ad_we, sr_we, dm_we, miso_buff, busy;
    logic [3:0] state_o;
`ifdef SPI_TXN_CNT_EN
    logic [7:0] txn_count;
    logic       abort_flag;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: phase number (spec codes), strobes seen in phase.
    int m_ph = 0;
    int m_cnt = 0;
    int m_txn = 0;
    bit m_abort = 0;

    always #5 clk = ~clk;

    spi_txn_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .sclk_pos  (sclk_pos),
        .sclk_neg  (sclk_neg),
        .rw_bit    (rw_bit),
        .ad_we     (ad_we),
        .sr_we     (sr_we),
        .dm_we     (dm_we),
        .miso_buff (miso_buff),
        .busy      (busy),
`ifdef SPI_TXN_CNT_EN
        .txn_count (txn_count),
        .abort_flag(abort_flag),
`endif
        .state_o   (state_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int nph;
        int need;
        bit strobe;
        if (reset) begin
            m_ph = 0; m_cnt = 0; m_txn = 0; m_abort = 0;
            return;
        end
        nph = m_ph;
        strobe = 0;
        need = 8;
        if (cs) begin
            if (m_ph != 0 && m_ph != 8) m_abort = 1;
            nph = 0;
        end else begin
            case (m_ph)
                0: nph = 1;
                1: begin strobe = sclk_pos; need = 8; end
                2: nph = rw_bit ? 3 : 6;
                3: nph = 4;
                4: nph = 5;
                5: begin strobe = sclk_neg; need = 8; end
                6: begin strobe = sclk_pos; need = 8; end
                7: nph = 8;
                default: nph = m_ph;
            endcase
            if (strobe && m_cnt + 1 == need)
                nph = (m_ph == 1) ? 2 : (m_ph == 5) ? 8 : 7;
        end
        if (nph == 8 && m_ph != 8) m_txn = (m_txn + 1) % 256;
        if (nph != m_ph) m_cnt = 0;
        else if (strobe) m_cnt++;
        m_ph = nph;
    endtask

    task automatic compare();
        chk("state_o", int'(state_o), m_ph);
        chk("ad_we", int'(ad_we), int'(m_ph == 2));
        chk("sr_we", int'(sr_we), int'(m_ph == 4));
        chk("miso_buff", int'(miso_buff), int'(m_ph == 5));
        chk("dm_we", int'(dm_we), int'(m_ph == 7));
        chk("busy", int'(busy), int'(m_ph != 0));
`ifdef SPI_TXN_CNT_EN
        chk("txn_count", int'(txn_count), m_txn);
        chk("abort_flag", int'(abort_flag), int'(m_abort));
`endif
    endtask

    // One clock: apply inputs, step model at the edge, compare on the falling edge.
    task automatic cyc(input logic c, input logic p, input logic n, input logic r, input logic rs = 1'b0);
        reset = rs; cs = c; sclk_pos = p; sclk_neg = n; rw_bit = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    // cs low then ADDR_BITS+1 sclk_pos, with stray sclk_neg between them; ends in GOT.
    task automatic addr_phase(input logic r);
        cyc(0, 0, 0, r);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc(0, 0, 1, r);
            cyc(0, 1, 0, r);
        end
    endtask

    task automatic write_txn();
        addr_phase(0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0);
            cyc(0, 1, 1, 0);
        end
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; cs = 1'b1; sclk_pos = 1'b0; sclk_neg = 1'b0; rw_bit = 1'b0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 1, 1, 0, 1);
        chk("lit_reset_state", int'(state_o), 0);
        chk("lit_reset_busy", int'(busy), 0);

        // Strobes in IDLE with cs high do nothing
        cyc(1, 1, 0, 0); cyc(1, 0, 1, 0);
        chk("lit_idle_stray", int'(state_o), 0);

        // Read transaction
        addr_phase(1);
        chk("lit_read_ad_we", int'(ad_we), 1);
        chk("lit_read_got", int'(state_o), 2);
        cyc(0, 0, 0, 1);
        chk("lit_read1", int'(state_o), 3);
        cyc(0, 0, 0, 0);
        chk("lit_read_sr_we", int'(sr_we), 1);
        cyc(0, 0, 0, 0);
        chk("lit_read3_miso", int'(miso_buff), 1);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 0);
            if (i < 7) cyc(0, 0, 1, 0);
        end
        chk("lit_read3_hold", int'(miso_buff), 1);
        cyc(0, 1, 1, 0);
        chk("lit_read_done", int'(state_o), 8);
        cyc(0, 1, 1, 0);
        chk("lit_done_stray", int'(state_o), 8);
        cyc(1, 0, 0, 0);

        // Write transaction
        addr_phase(0);
        cyc(0, 0, 0, 0);
        chk("lit_write_state", int'(state_o), 6);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0);
            cyc(0, 1, 0, 0);
        end
        chk("lit_write_dm_we", int'(dm_we), 1);
        cyc(0, 0, 0, 0);
        chk("lit_write_done", int'(state_o), 8);
        cyc(1, 0, 0, 0);

        // Abort mid write data
        addr_phase(0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("lit_abort_idle", int'(state_o), 0);
        chk("lit_abort_dm_we", int'(dm_we), 0);
`ifdef SPI_TXN_CNT_EN
        chk("lit_abort_flag", int'(abort_flag), 1);
        chk("lit_abort_txn", int'(txn_count), 2);
`endif

        // Reset mid READ3, then fresh transaction must need full address count
        addr_phase(1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0, 1);
        chk("lit_rst_state", int'(state_o), 0);
        chk("lit_rst_miso", int'(miso_buff), 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0);
        chk("lit_rst_get7", int'(state_o), 1);
        cyc(0, 1, 0, 1);
        chk("lit_rst_get8", int'(state_o), 2);
        cyc(1, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 20000; i++) begin
            cyc(($urandom_range(0, 99) < 2),
                ($urandom_range(0, 99) < 35),
                ($urandom_range(0, 99) < 35),
                1'($urandom),
                ($urandom_range(0, 999) < 2));
        end

`ifdef SPI_TXN_CNT_EN
        cyc(1, 0, 0, 0, 1);
        for (int t = 0; t < 257; t++) write_txn();
        chk("lit_257_txn", int'(txn_count), 1);
        chk("lit_257_abort", int'(abort_flag), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
